// File: rtl/country_road_sensor.sv
// Country-road vehicle detector: conditions the arrival and stop-line loop
// detectors, keeps a saturating count of queued cars and drives the request
// line x towards the junction controller, closing each request out against
// the controller's country light.
module country_road_sensor #(
  parameter int DEB_CYCLES = 4,
  parameter int QW         = 4,
  parameter int MAX_GREEN  = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          car_arrive,
  input  logic          car_depart,
  input  logic [1:0]    country,
  output logic          x,
  output logic [QW-1:0] queue_cnt,
  output logic          q_ovf,
  output logic          timeout
);

  localparam int DW = $clog2(DEB_CYCLES + 1);
  localparam int TW = $clog2(MAX_GREEN + 1);
  localparam logic [QW-1:0] QMAX = '1;

  typedef enum logic [1:0] {IDLE, REQ, SERVE, RELEASE} state_t;

  // Bit 0 carries the arrival detector, bit 1 the departure detector.
  logic [1:0]    raw;
  logic [1:0]    sync_p0;
  logic [1:0]    sync_p1;
  logic [1:0]    deb_p2;
  logic [1:0]    deb_p3;
  logic [DW-1:0] deb_cnt [2];
  logic          arr_ev;
  logic          dep_ev;

  logic [QW-1:0] q_next;
  logic          ovf_set;

  state_t        state;
  state_t        state_next;
  logic [TW-1:0] timer;
  logic          tmo_next;

  assign raw = {car_depart, car_arrive};

  // Stage p0/p1: two-flop synchroniser for the asynchronous loop detectors.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_p0 <= '0;
      sync_p1 <= '0;
    end else begin
      sync_p0 <= raw;
      sync_p1 <= sync_p0;
    end
  end

  // Stage p2/p3: debounced level accepts a change only after DEB_CYCLES
  // consecutive samples disagree with it; p3 holds the previous level so a
  // rising edge yields exactly one event per assertion.
  always_ff @(posedge clk) begin
    if (reset) begin
      deb_p2 <= '0;
      deb_p3 <= '0;
      for (int i = 0; i < 2; i++) deb_cnt[i] <= '0;
    end else begin
      deb_p3 <= deb_p2;
      for (int i = 0; i < 2; i++) begin
        if (sync_p1[i] == deb_p2[i]) begin
          deb_cnt[i] <= '0;
        end else if (deb_cnt[i] == DW'(DEB_CYCLES - 1)) begin
          deb_p2[i]  <= sync_p1[i];
          deb_cnt[i] <= '0;
        end else begin
          deb_cnt[i] <= deb_cnt[i] + DW'(1);
        end
      end
    end
  end

  assign arr_ev = deb_p2[0] & ~deb_p3[0];
  assign dep_ev = deb_p2[1] & ~deb_p3[1];

  // Next queue count: simultaneous arrival and departure cancel out, even at
  // the empty or full boundary; an arrival at full is dropped and flagged.
  always_comb begin
    q_next  = queue_cnt;
    ovf_set = 1'b0;
    case ({arr_ev, dep_ev})
      2'b10: begin
        if (queue_cnt == QMAX) ovf_set = 1'b1;
        else                   q_next  = queue_cnt + QW'(1);
      end
      2'b01: begin
        if (queue_cnt != '0) q_next = queue_cnt - QW'(1);
      end
      default: ;
    endcase
  end

  // Queue register; the overflow flag is sticky until the queue drains.
  always_ff @(posedge clk) begin
    if (reset) begin
      queue_cnt <= '0;
      q_ovf     <= 1'b0;
    end else begin
      queue_cnt <= q_next;
      q_ovf     <= (q_next == '0) ? 1'b0 : (q_ovf | ovf_set);
    end
  end

  // Request sequencing: queue-empty exit has priority over a controller
  // override, which has priority over the green-time limit.
  always_comb begin
    state_next = state;
    tmo_next   = 1'b0;
    case (state)
      IDLE:    if (queue_cnt != '0) state_next = REQ;
      REQ:     if (country == 2'b10) state_next = SERVE;
      SERVE: begin
        if (queue_cnt == '0) begin
          state_next = RELEASE;
        end else if (country != 2'b10) begin
          state_next = RELEASE;
        end else if (timer == TW'(MAX_GREEN - 1)) begin
          state_next = RELEASE;
          tmo_next   = 1'b1;
        end
      end
      RELEASE: if (country == 2'b00) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State, registered request, timeout pulse and green timer; the timer is
  // held at zero in REQ so it starts fresh on every entry to SERVE.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      x       <= 1'b0;
      timeout <= 1'b0;
      timer   <= '0;
    end else begin
      state   <= state_next;
      x       <= (state_next == REQ) || (state_next == SERVE);
      timeout <= tmo_next;
      if (state == REQ)        timer <= '0;
      else if (state == SERVE) timer <= timer + TW'(1);
    end
  end

endmodule
